// File: rtl/data_bus_rr_arbiter_pkg.sv
// Shared types and default address map for the SoC data-bus arbiter.
// Latency: n/a (types/constants only).
// Backpressure: n/a. Provides the slave index enum, default base/mask tables and idx_width().
package data_bus_rr_arbiter_pkg;

  localparam int DB_MAX_MASTERS = 8;
  localparam int DB_MAX_SLAVES  = 16;
  localparam int DB_NUM_SLAVES  = 8;

  // Index width with a floor of 1 so single-master builds still get a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [3:0] {
    SLV_BOOT_ROM = 4'd0,
    SLV_DATA_RAM = 4'd1,
    SLV_VRAM     = 4'd2,
    SLV_UART     = 4'd3,
    SLV_GPIO     = 4'd4,
    SLV_TIMER    = 4'd5,
    SLV_SPI      = 4'd6,
    SLV_PIXEL    = 4'd7
  } data_bus_slave_idx_t;

  // Per-peripheral address spaces.
  localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] BOOT_ROM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DATA_RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] DATA_RAM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] VRAM_BASE     = 32'h2000_0000;
  localparam logic [31:0] VRAM_MASK     = 32'hFFF0_0000;
  localparam logic [31:0] UART_BASE     = 32'h4000_0000;
  localparam logic [31:0] UART_MASK     = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE     = 32'h4000_1000;
  localparam logic [31:0] GPIO_MASK     = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE    = 32'h4000_2000;
  localparam logic [31:0] TIMER_MASK    = 32'hFFFF_F000;
  localparam logic [31:0] SPI_BASE      = 32'h4000_3000;
  localparam logic [31:0] SPI_MASK      = 32'hFFFF_F000;
  localparam logic [31:0] PIXEL_BASE    = 32'h5000_0000;
  localparam logic [31:0] PIXEL_MASK    = 32'hFFFF_0000;

  // Concatenation runs from the highest slave index down to index 0.
  localparam logic [DB_NUM_SLAVES-1:0][31:0] DEFAULT_SLAVE_BASE = {
    PIXEL_BASE, SPI_BASE, TIMER_BASE, GPIO_BASE,
    UART_BASE, VRAM_BASE, DATA_RAM_BASE, BOOT_ROM_BASE
  };
  localparam logic [DB_NUM_SLAVES-1:0][31:0] DEFAULT_SLAVE_MASK = {
    PIXEL_MASK, SPI_MASK, TIMER_MASK, GPIO_MASK,
    UART_MASK, VRAM_MASK, DATA_RAM_MASK, BOOT_ROM_MASK
  };

  // Mux-steering state bundled for SoC top-level wiring; sized for the largest build.
  typedef struct packed {
    logic [2:0]  sel_master;
    logic [2:0]  rsp_master;
    logic [15:0] rsp_slave;
  } data_bus_rr_state_t;

endpackage

// File: rtl/data_bus_rr_arbiter_if.sv
// Data-bus bundle between masters, slaves and the round-robin arbiter.
// Latency: n/a (wiring only).
// Backpressure: s_gnt from slaves gates m_gnt. Modport master = requesters/slaves side, slave = arbiter side.
interface data_bus_rr_arbiter_if
  import data_bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 8
);
  localparam int IDX_W = idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]       m_req;
  logic [NUM_MASTERS-1:0][31:0] m_addr;
  logic [NUM_MASTERS-1:0]       m_gnt;
  logic [NUM_MASTERS-1:0]       m_rvalid;
  logic [NUM_MASTERS-1:0]       m_err;
  logic [NUM_SLAVES-1:0]        s_gnt;
  logic [NUM_SLAVES-1:0]        s_req;
  logic [IDX_W-1:0]             sel_master;
  logic [IDX_W-1:0]             rsp_master;
  logic [NUM_SLAVES-1:0]        rsp_slave;

  // Environment view: masters drive requests, slaves drive readiness.
  modport master (
    output m_req, m_addr, s_gnt,
    input  m_gnt, m_rvalid, m_err, s_req, sel_master, rsp_master, rsp_slave
  );

  // Arbiter view.
  modport slave (
    input  m_req, m_addr, s_gnt,
    output m_gnt, m_rvalid, m_err, s_req, sel_master, rsp_master, rsp_slave
  );
endinterface

// File: rtl/data_bus_rr_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is accepted.
// Ports: req (request vector), ptr (start index, < NUM_MASTERS), any, win_oh (one-hot), win_idx.
module rr_priority_picker
  import data_bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   any,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [IDX_W-1:0]       win_idx
);

  logic [IDX_W:0] cand;

  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      // One extra bit so ptr + off cannot overflow before the modulo wrap.
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any     = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    win_oh = any ? (NUM_MASTERS'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/data_bus_rr_arbiter.sv
// Round-robin data-bus arbiter with base/mask address decode and internal decode-error responder.
// Latency: grant/select combinational; response (m_rvalid, rsp_master, rsp_slave, m_err) one cycle after accept.
// Backpressure: a stalled slave (s_gnt low) withholds m_gnt and freezes the pointer; decode errors accept at once.
// Ports: clk, rst_n (async active-low), bus (slave modport: requests, grants, selects, response steering),
//        err_count (saturating decode-error count).
module data_bus_rr_arbiter
  import data_bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 8,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = DEFAULT_SLAVE_MASK,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_bus_rr_arbiter_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  logic [IDX_W-1:0]       rr_ptr;
  logic                   any;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       ptr_next;
  logic [31:0]            win_addr;
  logic                   hit;
  logic [NUM_SLAVES-1:0]  hit_oh;
  logic                   accept;
  logic                   dec_err;

  logic [NUM_MASTERS-1:0] rvalid_q;
  logic [NUM_MASTERS-1:0] err_q;
  logic [IDX_W-1:0]       rsp_master_q;
  logic [NUM_SLAVES-1:0]  rsp_slave_q;
  logic [ERR_CNT_W-1:0]   err_count_q;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req     (bus.m_req),
    .ptr     (rr_ptr),
    .any     (any),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign win_addr = bus.m_addr[win_idx];

  // Ascending scan with a found flag: overlapping windows resolve to the lowest index.
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (!hit && ((win_addr & SLAVE_MASK[s]) == SLAVE_BASE[s])) begin
        hit       = 1'b1;
        hit_oh[s] = 1'b1;
      end
    end
  end

  // Unmapped addresses are answered internally, so they never wait on a slave.
  assign dec_err = any && !hit;
  assign accept  = dec_err || (any && |(hit_oh & bus.s_gnt));

  assign ptr_next = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;

  assign bus.m_gnt      = accept ? win_oh : '0;
  assign bus.s_req      = (any && hit) ? hit_oh : '0;
  assign bus.sel_master = any ? win_idx : rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      rvalid_q     <= '0;
      err_q        <= '0;
      rsp_master_q <= '0;
      rsp_slave_q  <= '0;
      err_count_q  <= '0;
    end else begin
      rvalid_q    <= accept ? win_oh : '0;
      err_q       <= dec_err ? win_oh : '0;
      rsp_slave_q <= (accept && hit) ? hit_oh : '0;
      if (accept) begin
        rr_ptr       <= ptr_next;
        rsp_master_q <= win_idx;
      end
      if (dec_err && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.m_rvalid   = rvalid_q;
  assign bus.m_err      = err_q;
  assign bus.rsp_master = rsp_master_q;
  assign bus.rsp_slave  = rsp_slave_q;
  assign err_count      = err_count_q;

endmodule
